layer_sequencer: RTL and testbench

Top-level layer scheduler for the inference pipeline. It drives the 4-bit layer code `cs` shared by the weight stores and the compute datapath. It steps through LAYER0, LAYER1, LAYER2, LAYER3 and AFFINE. For each layer it waits until the weight stores have finished reloading their 288-word banks, then issues a one-cycle start to the datapath and waits for its completion. It also masks the stale `valid` that weight stores hold across a `cs` change, and flags loads that never complete.

---
 rtl/layer_sequencer_pkg.sv | 58 +++++
 rtl/layer_sequencer_if.sv | 36 +++
 rtl/layer_sequencer_ws_guard_timer.sv | 55 +++++
 rtl/layer_sequencer.sv | 142 ++++++++++++++
 tb/tb_layer_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// layer_sequencer_pkg
//   Shared definitions for the layer scheduler, the weight stores and the
//   compute datapath:
//     - layer_code_e : 4-bit layer code carried on `cs`
//     - seq_state_e  : sequencer FSM states
//     - next_layer() : fixed layer order LAYER0..LAYER3 -> AFFINE -> FIN
//     - is_layer()   : true for codes that select a weight bank
//   IDLE and FIN match no layer code, so every transition is a visible `cs`
//   change to the weight stores.
// -----------------------------------------------------------------------------
package layer_sequencer_pkg;

  typedef enum logic [3:0] {
    CS_IDLE   = 4'h0,
    CS_LAYER0 = 4'h1,
    CS_LAYER1 = 4'h2,
    CS_LAYER2 = 4'h3,
    CS_LAYER3 = 4'h4,
    CS_AFFINE = 4'h5,
    CS_FIN    = 4'hF
  } layer_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_W = 2'd1,
    ST_RUN    = 2'd2,
    ST_FIN    = 2'd3
  } seq_state_e;

  // Words per weight bank reload; informs the nominal WAIT_W duration.
  localparam int unsigned BANK_WORDS = 288;

  // Successor of a layer code. AFFINE is followed by FIN (no wrap-around);
  // anything that is not a layer code falls back to IDLE.
  function automatic layer_code_e next_layer(input layer_code_e code);
    layer_code_e nxt;
    case (code)
      CS_LAYER0: nxt = CS_LAYER1;
      CS_LAYER1: nxt = CS_LAYER2;
      CS_LAYER2: nxt = CS_LAYER3;
      CS_LAYER3: nxt = CS_AFFINE;
      CS_AFFINE: nxt = CS_FIN;
      default:   nxt = CS_IDLE;
    endcase
    return nxt;
  endfunction

  function automatic logic is_layer(input layer_code_e code);
    logic r;
    case (code)
      CS_LAYER0, CS_LAYER1, CS_LAYER2, CS_LAYER3, CS_AFFINE: r = 1'b1;
      default:                                               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// -----------------------------------------------------------------------------
// layer_sequencer_if
//   Handshake bundle between the layer sequencer and its environment.
//     start     : request to run the full layer sequence (sampled in IDLE)
//     ws_valid  : AND of all weight-store valid outputs
//     dp_done   : one-cycle completion pulse from the datapath
//     cs        : current layer code
//     dp_start  : one-cycle pulse, weights ready for the current layer
//     busy      : sequencer not in IDLE
//     done      : one-cycle pulse when AFFINE completes
//     err       : sticky weight-load timeout flag
//   master : the sequencer side; slave : weight stores / datapath / host side.
// -----------------------------------------------------------------------------
interface layer_sequencer_if;
  import layer_sequencer_pkg::*;

  logic        start;
  logic        ws_valid;
  logic        dp_done;
  layer_code_e cs;
  logic        dp_start;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start, ws_valid, dp_done,
    output cs, dp_start, busy, done, err
  );

  modport slave (
    output start, ws_valid, dp_done,
    input  cs, dp_start, busy, done, err
  );

endinterface

// File: rtl/layer_sequencer_ws_guard_timer.sv
// -----------------------------------------------------------------------------
// ws_guard_timer
//   Guard and timeout counters for the WAIT_W phase of the layer sequencer.
//     clk           : system clock, rising edge
//     rst           : synchronous active-high reset
//     i_restart     : reload gcnt with GUARD and clear tcnt (on WAIT_W entry)
//     i_run         : count (sequencer is in WAIT_W)
//     o_guard_done  : gcnt has reached 0, ws_valid may be trusted
//     o_timeout     : tcnt reaches TIMEOUT on the coming edge
//   Both counters saturate and never wrap.
// -----------------------------------------------------------------------------
module ws_guard_timer #(
  parameter int unsigned GUARD   = 3,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  input  logic i_run,
  output logic o_guard_done,
  output logic o_timeout
);

  localparam int unsigned GW = $clog2(GUARD + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [GW-1:0] GUARD_V   = GW'(GUARD);
  localparam logic [TW-1:0] TMAX_V    = TW'(TIMEOUT);
  localparam logic [TW-1:0] TLAST_V   = TW'(TIMEOUT - 1);

  logic [GW-1:0] r_gcnt;
  logic [TW-1:0] r_tcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gcnt <= '0;
      r_tcnt <= '0;
    end else if (i_restart) begin
      r_gcnt <= GUARD_V;
      r_tcnt <= '0;
    end else if (i_run) begin
      if (r_gcnt != '0)
        r_gcnt <= r_gcnt - GW'(1);
      if (r_tcnt != TMAX_V)
        r_tcnt <= r_tcnt + TW'(1);
    end
  end

  assign o_guard_done = (r_gcnt == '0);

  // Flagged one count early so that err/IDLE become visible on the same edge
  // at which tcnt reaches TIMEOUT, keeping the error registered.
  assign o_timeout = (r_tcnt >= TLAST_V);

endmodule

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//   Top-level layer scheduler. Walks LAYER0..LAYER3 and AFFINE; for each
//   layer it waits for the weight stores to reload (ignoring stale ws_valid
//   for GUARD cycles after every cs change), pulses dp_start, and waits for
//   dp_done. A weight load that exceeds TIMEOUT cycles sets the sticky err
//   flag and returns to IDLE; further starts are ignored until rst.
//     clk  : system clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : layer_sequencer_if.master (start, ws_valid, dp_done in;
//            cs, dp_start, busy, done, err out)
//   Parameters: GUARD (>= 3) stale-valid mask cycles,
//               TIMEOUT (> GUARD + 290) WAIT_W cycle limit.
//   All outputs are registered.
// -----------------------------------------------------------------------------
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int unsigned GUARD   = 3,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  layer_sequencer_if.master     bus
);

  seq_state_e  r_state;
  layer_code_e r_cs;
  logic        r_dp_start;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  seq_state_e  w_state_nxt;
  layer_code_e w_cs_nxt;
  logic        w_dp_start_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic        w_restart;
  logic        w_run;
  logic        w_guard_done;
  logic        w_timeout;

  assign w_run = (r_state == ST_WAIT_W);

  ws_guard_timer #(
    .GUARD   (GUARD),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_restart    (w_restart),
    .i_run        (w_run),
    .o_guard_done (w_guard_done),
    .o_timeout    (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cs       <= CS_IDLE;
      r_dp_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cs       <= w_cs_nxt;
      r_dp_start <= w_dp_start_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Outputs are computed as next-state values so that every output register
  // changes on the same edge as the state it belongs to.
  always_comb begin
    w_state_nxt    = r_state;
    w_cs_nxt       = r_cs;
    w_dp_start_nxt = 1'b0;
    w_done_nxt     = 1'b0;
    w_err_nxt      = r_err;
    w_restart      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start && !r_err) begin
          w_state_nxt = ST_WAIT_W;
          w_cs_nxt    = CS_LAYER0;
          w_restart   = 1'b1;
        end
      end

      ST_WAIT_W: begin
        // Ready weights take precedence over a timeout sampled on the same edge.
        if (w_guard_done && bus.ws_valid) begin
          w_state_nxt    = ST_RUN;
          w_dp_start_nxt = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_cs_nxt    = CS_IDLE;
          w_err_nxt   = 1'b1;
        end
      end

      ST_RUN: begin
        if (bus.dp_done) begin
          if (r_cs == CS_AFFINE) begin
            w_state_nxt = ST_FIN;
            w_cs_nxt    = CS_FIN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT_W;
            w_cs_nxt    = next_layer(r_cs);
            w_restart   = 1'b1;
          end
        end
      end

      ST_FIN: begin
        w_state_nxt = ST_IDLE;
        w_cs_nxt    = CS_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cs_nxt    = CS_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign bus.cs       = r_cs;
  assign bus.dp_start = r_dp_start;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
//   Directed bench for layer_sequencer. A per-cycle task models the weight
//   stores (ws_valid VD cycles after each cs change, optionally stuck or
//   permanently high) and the datapath (dp_done DP_LAT cycles after dp_start).
// -----------------------------------------------------------------------------
module tb_layer_sequencer;
  import layer_sequencer_pkg::*;

  localparam int GUARD   = 3;
  localparam int TIMEOUT = 1023;
  localparam int VD      = 291;
  localparam int DP_LAT  = 50;
  localparam int PERIOD  = VD + DP_LAT;          // 341 cycles per layer
  localparam int DONE_T  = 1 + 5 * PERIOD;       // done seen 1706 ticks after start
  localparam int STALE_T = 1 + 5 * (GUARD + 1 + DP_LAT);

  logic clk = 1'b0;
  logic rst = 1'b1;

  layer_sequencer_if bus ();

  layer_sequencer #(
    .GUARD   (GUARD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int t, since, last_span, n_log, n_dp, n_done, done_t, err_seen, busy_bad, dcnt;
  bit timed_out, aborted, rst_pending;
  bit m_stale, m_stuck, m_spur, m_rst_l3;
  logic [3:0] prev_cs;
  logic [3:0] seq_log [16];
  int         dp_since [8];
  logic [3:0] rst_cs;
  logic       rst_busy, rst_done, rst_dps;

  logic [3:0] exp_nom [7] = '{CS_LAYER0, CS_LAYER1, CS_LAYER2, CS_LAYER3,
                              CS_AFFINE, CS_FIN, CS_IDLE};
  logic [3:0] exp_to  [4] = '{CS_LAYER0, CS_LAYER1, CS_LAYER2, CS_IDLE};
  logic [3:0] exp_rst [5] = '{CS_LAYER0, CS_LAYER1, CS_LAYER2, CS_LAYER3, CS_IDLE};

  function automatic bit model_is_layer(input logic [3:0] c);
    return (c == 4'h1) || (c == 4'h2) || (c == 4'h3) || (c == 4'h4) || (c == 4'h5);
  endfunction

  // One clock: observe outputs #1 after the edge, then drive inputs for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    if (bus.cs !== prev_cs) begin
      last_span = since + 1;
      since     = 0;
      if (n_log < 16) seq_log[n_log] = bus.cs;
      n_log++;
      prev_cs = bus.cs;
    end else begin
      since++;
    end
    if (bus.dp_start === 1'b1) begin
      if (n_dp < 8) dp_since[n_dp] = since;
      n_dp++;
    end
    if (bus.done === 1'b1) begin
      n_done++;
      done_t = t;
    end
    if (bus.err === 1'b1) err_seen++;
    if (bus.busy !== (bus.cs != CS_IDLE)) busy_bad++;

    bus.start = 1'b0;
    if (m_spur && bus.cs == CS_LAYER1 && bus.dp_start === 1'b1) bus.start = 1'b1;

    if (dcnt > 0) dcnt--;
    if (bus.dp_start === 1'b1) dcnt = DP_LAT;
    bus.dp_done = (dcnt == 1);
    if (m_spur && bus.cs == CS_LAYER2 && since == 100) bus.dp_done = 1'b1;

    bus.ws_valid = m_stale ||
                   (model_is_layer(bus.cs) && !(m_stuck && bus.cs == CS_LAYER2) && since >= VD - 1);

    if (rst_pending) begin
      rst         = 1'b0;
      rst_pending = 1'b0;
      rst_cs      = bus.cs;
      rst_busy    = bus.busy;
      rst_done    = bus.done;
      rst_dps     = bus.dp_start;
      dcnt        = 0;
      bus.dp_done = 1'b0;
      aborted     = 1'b1;
    end else if (m_rst_l3 && bus.cs == CS_LAYER3 && since == VD + 10) begin
      rst         = 1'b1;
      rst_pending = 1'b1;
    end
  endtask

  // Pulse start and follow the sequence until cs returns to IDLE (or abort/budget).
  task automatic run_sequence();
    t = 0; since = 0; last_span = 0; n_log = 0; n_dp = 0; n_done = 0; done_t = 0;
    err_seen = 0; busy_bad = 0; dcnt = 0;
    timed_out = 1'b0; aborted = 1'b0; rst_pending = 1'b0;
    for (int i = 0; i < 16; i++) seq_log[i] = 4'hE;
    for (int i = 0; i < 8; i++) dp_since[i] = -1;
    prev_cs   = bus.cs;
    bus.start = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      tick();
      if (aborted) break;
      if (n_log > 0 && bus.cs == CS_IDLE) break;
      if (k == 3999) timed_out = 1'b1;
    end
    bus.start   = 1'b0;
    bus.dp_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.ws_valid = 1'b1; bus.dp_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b0; bus.ws_valid = 1'b0; bus.dp_done = 1'b0;
    vectors++; if (bus.cs !== CS_IDLE) begin miscompares++; $display("FAIL reset_cs: got %h expected %h", bus.cs, CS_IDLE); end
    vectors++; if (bus.dp_start !== 1'b0) begin miscompares++; $display("FAIL reset_dp_start: got %b expected 0", bus.dp_start); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (bus.cs !== CS_IDLE) begin miscompares++; $display("FAIL idle_no_start_cs: got %h expected %h", bus.cs, CS_IDLE); end
  endtask

  task automatic test_nominal();
    m_stale = 0; m_stuck = 0; m_spur = 0; m_rst_l3 = 0;
    run_sequence();
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL nominal_budget: sequence did not return to IDLE within 4000 cycles"); end
    vectors++; if (n_log !== 7) begin miscompares++; $display("FAIL nominal_cs_changes: got %0d expected 7", n_log); end
    for (int i = 0; i < 7; i++) begin
      vectors++; if (seq_log[i] !== exp_nom[i]) begin miscompares++; $display("FAIL nominal_cs[%0d]: got %h expected %h", i, seq_log[i], exp_nom[i]); end
    end
    vectors++; if (n_dp !== 5) begin miscompares++; $display("FAIL nominal_dp_start_count: got %0d expected 5", n_dp); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (dp_since[i] !== VD) begin miscompares++; $display("FAIL nominal_dp_start_lat[%0d]: got %0d expected %0d", i, dp_since[i], VD); end
    end
    vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL nominal_done_count: got %0d expected 1", n_done); end
    vectors++; if (done_t !== DONE_T) begin miscompares++; $display("FAIL nominal_done_time: got %0d expected %0d", done_t, DONE_T); end
    vectors++; if (err_seen !== 0) begin miscompares++; $display("FAIL nominal_err: err high for %0d cycles expected 0", err_seen); end
    vectors++; if (busy_bad !== 0) begin miscompares++; $display("FAIL nominal_busy: %0d cycles wrong expected 0", busy_bad); end
  endtask

  task automatic test_stale_valid();
    m_stale = 1; m_stuck = 0; m_spur = 0; m_rst_l3 = 0;
    run_sequence();
    vectors++; if (n_dp !== 5) begin miscompares++; $display("FAIL stale_dp_start_count: got %0d expected 5", n_dp); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (dp_since[i] !== GUARD + 1) begin miscompares++; $display("FAIL stale_dp_start_lat[%0d]: got %0d expected %0d", i, dp_since[i], GUARD + 1); end
    end
    vectors++; if (done_t !== STALE_T) begin miscompares++; $display("FAIL stale_done_time: got %0d expected %0d", done_t, STALE_T); end
    vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL stale_done_count: got %0d expected 1", n_done); end
    m_stale = 0;
    bus.ws_valid = 1'b0;
  endtask

  task automatic test_timeout();
    int bad;
    m_stale = 0; m_stuck = 1; m_spur = 0; m_rst_l3 = 0;
    run_sequence();
    vectors++; if (n_log !== 4) begin miscompares++; $display("FAIL timeout_cs_changes: got %0d expected 4", n_log); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (seq_log[i] !== exp_to[i]) begin miscompares++; $display("FAIL timeout_cs[%0d]: got %h expected %h", i, seq_log[i], exp_to[i]); end
    end
    vectors++; if (last_span !== TIMEOUT) begin miscompares++; $display("FAIL timeout_latency: got %0d expected %0d", last_span, TIMEOUT); end
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL timeout_err: got %b expected 1", bus.err); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL timeout_busy: got %b expected 0", bus.busy); end
    vectors++; if (n_dp !== 2) begin miscompares++; $display("FAIL timeout_dp_start_count: got %0d expected 2", n_dp); end
    vectors++; if (n_done !== 0) begin miscompares++; $display("FAIL timeout_done_count: got %0d expected 0", n_done); end
    m_stuck = 0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      bus.start = (k < 3);
      bus.ws_valid = 1'b1;
      @(posedge clk); #1;
      if (bus.cs !== CS_IDLE || bus.busy !== 1'b0 || bus.dp_start !== 1'b0) bad++;
    end
    bus.start = 1'b0; bus.ws_valid = 1'b0;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL timeout_start_ignored: %0d active cycles expected 0", bad); end
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL timeout_err_sticky: got %b expected 1", bus.err); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL timeout_err_cleared: got %b expected 0", bus.err); end
  endtask

  task automatic test_spurious();
    m_stale = 0; m_stuck = 0; m_spur = 1; m_rst_l3 = 0;
    run_sequence();
    vectors++; if (n_log !== 7) begin miscompares++; $display("FAIL spurious_cs_changes: got %0d expected 7", n_log); end
    for (int i = 0; i < 7; i++) begin
      vectors++; if (seq_log[i] !== exp_nom[i]) begin miscompares++; $display("FAIL spurious_cs[%0d]: got %h expected %h", i, seq_log[i], exp_nom[i]); end
    end
    vectors++; if (n_dp !== 5) begin miscompares++; $display("FAIL spurious_dp_start_count: got %0d expected 5", n_dp); end
    vectors++; if (done_t !== DONE_T) begin miscompares++; $display("FAIL spurious_done_time: got %0d expected %0d", done_t, DONE_T); end
    vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL spurious_done_count: got %0d expected 1", n_done); end
    m_spur = 0;
  endtask

  task automatic test_reset_mid_run();
    m_stale = 0; m_stuck = 0; m_spur = 0; m_rst_l3 = 1;
    run_sequence();
    m_rst_l3 = 0;
    vectors++; if (aborted !== 1'b1) begin miscompares++; $display("FAIL midrst_reached_layer3: got %b expected 1", aborted); end
    vectors++; if (rst_cs !== CS_IDLE) begin miscompares++; $display("FAIL midrst_cs: got %h expected %h", rst_cs, CS_IDLE); end
    vectors++; if (rst_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", rst_busy); end
    vectors++; if (rst_done !== 1'b0) begin miscompares++; $display("FAIL midrst_done: got %b expected 0", rst_done); end
    vectors++; if (rst_dps !== 1'b0) begin miscompares++; $display("FAIL midrst_dp_start: got %b expected 0", rst_dps); end
    vectors++; if (n_done !== 0) begin miscompares++; $display("FAIL midrst_done_count: got %0d expected 0", n_done); end
    for (int i = 0; i < 5; i++) begin
      vectors++; if (seq_log[i] !== exp_rst[i]) begin miscompares++; $display("FAIL midrst_cs[%0d]: got %h expected %h", i, seq_log[i], exp_rst[i]); end
    end
    run_sequence();
    vectors++; if (seq_log[0] !== CS_LAYER0) begin miscompares++; $display("FAIL midrst_restart_first: got %h expected %h", seq_log[0], CS_LAYER0); end
    vectors++; if (n_log !== 7) begin miscompares++; $display("FAIL midrst_restart_changes: got %0d expected 7", n_log); end
    vectors++; if (done_t !== DONE_T) begin miscompares++; $display("FAIL midrst_restart_done_time: got %0d expected %0d", done_t, DONE_T); end
    vectors++; if (n_dp !== 5) begin miscompares++; $display("FAIL midrst_restart_dp_start_count: got %0d expected 5", n_dp); end
  endtask

  task automatic test_back_to_back();
    m_stale = 0; m_stuck = 0; m_spur = 0; m_rst_l3 = 0;
    run_sequence();
    vectors++; if (done_t !== DONE_T) begin miscompares++; $display("FAIL b2b_first_done_time: got %0d expected %0d", done_t, DONE_T); end
    vectors++; if (bus.cs !== CS_IDLE || bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_gap: cs %h busy %b expected %h 0", bus.cs, bus.busy, CS_IDLE); end
    run_sequence();
    vectors++; if (n_log !== 7) begin miscompares++; $display("FAIL b2b_second_cs_changes: got %0d expected 7", n_log); end
    for (int i = 0; i < 7; i++) begin
      vectors++; if (seq_log[i] !== exp_nom[i]) begin miscompares++; $display("FAIL b2b_second_cs[%0d]: got %h expected %h", i, seq_log[i], exp_nom[i]); end
    end
    vectors++; if (done_t !== DONE_T) begin miscompares++; $display("FAIL b2b_second_done_time: got %0d expected %0d", done_t, DONE_T); end
    vectors++; if (n_dp !== 5) begin miscompares++; $display("FAIL b2b_second_dp_start_count: got %0d expected 5", n_dp); end
    vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL b2b_second_done_count: got %0d expected 1", n_done); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ws_valid = 1'b0;
    bus.dp_done = 1'b0;
    m_stale = 0; m_stuck = 0; m_spur = 0; m_rst_l3 = 0;
    test_reset();
    test_nominal();
    test_stale_valid();
    test_timeout();
    test_spurious();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
